// File: rtl/sisc_mem_resp_pkg.sv
// Shared definitions for the SISC memory responder: FSM state codes, error causes, counter width.
package sisc_mem_pkg;

  localparam int CTR_W = 4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_WAIT   = 2'd1;
  localparam state_t ST_ACCESS = 2'd2;
  localparam state_t ST_RESP   = 2'd3;

  typedef logic [1:0] err_cause_t;
  localparam err_cause_t ERR_NONE      = 2'd0;
  localparam err_cause_t ERR_RANGE     = 2'd1;
  localparam err_cause_t ERR_IFETCH_WE = 2'd2;
  localparam err_cause_t ERR_PROT      = 2'd3;

  // Range violations take precedence so a bad address is never reported as a protection hit.
  function automatic err_cause_t err_cause(input logic out_of_range,
                                           input logic ifetch_we,
                                           input logic prot_hit);
    if (out_of_range)   return ERR_RANGE;
    else if (ifetch_we) return ERR_IFETCH_WE;
    else if (prot_hit)  return ERR_PROT;
    else                return ERR_NONE;
  endfunction

endpackage

// File: rtl/sisc_mem_resp_if.sv
// Request/response handshake bundle between the SISC control/datapath (master) and the memory responder (slave).
interface sisc_mem_resp_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_ifetch;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_ifetch, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_ifetch, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/sisc_wait_ctr.sv
// Loadable down-counter for wait-state insertion; done is high while the count sits at 1.
module sisc_wait_ctr
  import sisc_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst_f,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [CTR_W-1:0] count_q;
  logic [CTR_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_f) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == CTR_W'(1));

endmodule

// File: rtl/sisc_mem_resp.sv
// SISC memory-side responder: one request at a time, programmable wait states, range/ifetch/protection errors.
// Optional write protection below PROT_BASE is enabled by defining SISC_MEM_PROT_EN.
module sisc_mem_resp
  import sisc_mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1,
  parameter int PROT_BASE   = 64
) (
  input  logic            clk,
  input  logic            rst_f,
  sisc_mem_resp_if.slave  bus,
  output logic            busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CTR_W-1:0] WAIT_LD = CTR_W'(WAIT_CYCLES);

`ifdef SISC_MEM_PROT_EN
  localparam logic PROT_EN = 1'b1;
`else
  localparam logic PROT_EN = 1'b0;
`endif

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic              ifetch_q, ifetch_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              wait_done;
  logic              out_of_range;
  logic              prot_hit;
  err_cause_t        cause;
  logic              mem_we;
  logic [IDX_W-1:0]  idx;

  assign accept = bus.req_valid && (state_q == ST_IDLE);
  assign idx    = addr_q[IDX_W-1:0];

  // Compare at a width wider than the address so high addresses never alias onto implemented words.
  assign out_of_range = (33'(addr_q) >= 33'(DEPTH));
  assign prot_hit     = PROT_EN && we_q && (33'(addr_q) < 33'(PROT_BASE));
  assign cause        = err_cause(out_of_range, ifetch_q && we_q, prot_hit);
  assign mem_we       = (state_q == ST_ACCESS) && we_q && (cause == ERR_NONE);

  sisc_wait_ctr u_wait_ctr (
    .clk      (clk),
    .rst_f    (rst_f),
    .load     (accept),
    .load_val (WAIT_LD),
    .en       (state_q == ST_WAIT),
    .done     (wait_done)
  );

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    ifetch_d = ifetch_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d     = bus.req_we;
          ifetch_d = bus.req_ifetch;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          state_d  = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (wait_done) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        err_d   = (cause != ERR_NONE);
        rdata_d = ((cause == ERR_NONE) && !we_q) ? mem[idx] : '0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      ifetch_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      ifetch_q <= ifetch_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // The array is never cleared; a write landing on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!rst_f && mem_we) begin
      mem[idx] <= wdata_q;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sisc_mem_resp.sv
// Scoreboard-driven bench for sisc_mem_resp; protection expectations follow SISC_MEM_PROT_EN.
module tb_sisc_mem_resp;

  localparam int DEPTH       = 256;
  localparam int WAIT_CYCLES = 1;
  localparam int PROT_BASE   = 64;
  localparam int BOUND       = 100;

`ifdef SISC_MEM_PROT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_f;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [31:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  sisc_mem_resp_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  sisc_mem_resp #(
    .ADDR_W      (16),
    .DATA_W      (32),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAIT_CYCLES),
    .PROT_BASE   (PROT_BASE)
  ) dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus),
    .busy  (busy)
  );

  // Drive one request until it is accepted; when tracked, the expected response is pushed at the accept edge.
  task automatic issue_req(input logic we, input logic ifetch, input logic [15:0] addr,
                           input logic [31:0] wdata, input bit track, output int waited);
    exp_t e;
    logic bad;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_ifetch = ifetch;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    waited = 0;
    while (bus.req_ready !== 1'b1 && waited < BOUND) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= BOUND) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout addr=%h req_ready=%b required 1", addr, bus.req_ready);
    end
    @(posedge clk);
    if (track) begin
      bad = (32'(addr) >= DEPTH) || (ifetch && we) || (PROT_EN && we && (32'(addr) < PROT_BASE));
      e.err   = bad;
      e.rdata = '0;
      if (!bad) begin
        if (we) model_mem[addr[7:0]] = wdata;
        else    e.rdata = model_mem[addr[7:0]];
      end
      sb.push_back(e);
    end
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_ifetch = 1'b0;
  endtask

  // Wait for rsp_valid (counting edges after the accept edge) and pop the matching expectation.
  task automatic collect(output int lat, output exp_t e);
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < BOUND) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= BOUND) begin
      checks++;
      errors++;
      $display("[TB] FAIL rsp_timeout rsp_valid=%b required 1", bus.rsp_valid);
    end
    e = (sb.size() > 0) ? sb.pop_front() : '0;
  endtask

  task automatic test_reset();
    rst_f          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_ifetch = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b0;
    repeat (3) @(negedge clk);
    rst_f = 1'b0;
    checks += 5;
    if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    if (bus.rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rsp_rdata got=%h exp=0", bus.rsp_rdata); end
    if (bus.rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_err got=%b exp=0", bus.rsp_err); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_write_read();
    int w, lat;
    exp_t e;
    bus.rsp_ready = 1'b1;
    issue_req(1'b1, 1'b0, 16'h0050, 32'hDEADBEEF, 1'b1, w);
    collect(lat, e);
    checks += 3;
    if (lat !== WAIT_CYCLES + 1) begin errors++; $display("[TB] FAIL wr_latency got=%0d exp=%0d", lat, WAIT_CYCLES + 1); end
    if (bus.rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL wr_err got=%b exp=0", bus.rsp_err); end
    if (bus.rsp_rdata !== e.rdata) begin errors++; $display("[TB] FAIL wr_rdata got=%h exp=%h", bus.rsp_rdata, e.rdata); end
    issue_req(1'b0, 1'b0, 16'h0050, 32'h0, 1'b1, w);
    collect(lat, e);
    checks += 3;
    if (lat !== WAIT_CYCLES + 1) begin errors++; $display("[TB] FAIL rd_latency got=%0d exp=%0d", lat, WAIT_CYCLES + 1); end
    if (bus.rsp_err !== e.err) begin errors++; $display("[TB] FAIL rd_err got=%b exp=%b", bus.rsp_err, e.err); end
    if (bus.rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rd_rdata got=%h exp=deadbeef", bus.rsp_rdata); end
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    int w, lat;
    exp_t e;
    logic [15:0] addrs [3];
    logic        wes [3];
    addrs = '{16'h0100, 16'h0150, 16'hFFFF};
    wes   = '{1'b0, 1'b1, 1'b0};
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue_req(wes[i], 1'b0, addrs[i], 32'h0BAD0BAD, 1'b1, w);
      collect(lat, e);
      checks += 2;
      if (bus.rsp_err !== 1'b1) begin errors++; $display("[TB] FAIL oor_err addr=%h got=%b exp=1", addrs[i], bus.rsp_err); end
      if (bus.rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL oor_rdata addr=%h got=%h exp=0", addrs[i], bus.rsp_rdata); end
    end
    issue_req(1'b0, 1'b0, 16'h0050, 32'h0, 1'b1, w);
    collect(lat, e);
    checks++;
    if (bus.rsp_rdata !== e.rdata) begin errors++; $display("[TB] FAIL oor_alias got=%h exp=%h", bus.rsp_rdata, e.rdata); end
    @(negedge clk);
  endtask

  task automatic test_ifetch_we();
    int w, lat;
    exp_t e;
    bus.rsp_ready = 1'b1;
    issue_req(1'b1, 1'b0, 16'h0010, 32'hCAFEF00D, 1'b1, w);
    collect(lat, e);
    issue_req(1'b1, 1'b1, 16'h0010, 32'h12345678, 1'b1, w);
    collect(lat, e);
    checks += 2;
    if (bus.rsp_err !== 1'b1) begin errors++; $display("[TB] FAIL ifwe_err got=%b exp=1", bus.rsp_err); end
    if (bus.rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL ifwe_rdata got=%h exp=0", bus.rsp_rdata); end
    issue_req(1'b0, 1'b1, 16'h0010, 32'h0, 1'b1, w);
    collect(lat, e);
    checks += 2;
    if (bus.rsp_err !== e.err) begin errors++; $display("[TB] FAIL ifetch_err got=%b exp=%b", bus.rsp_err, e.err); end
    if (bus.rsp_rdata !== e.rdata) begin errors++; $display("[TB] FAIL ifetch_rdata got=%h exp=%h", bus.rsp_rdata, e.rdata); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int w, lat;
    exp_t e;
    bus.rsp_ready = 1'b0;
    issue_req(1'b0, 1'b0, 16'h0050, 32'h0, 1'b1, w);
    collect(lat, e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks += 3;
      if (bus.rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid cyc=%0d got=%b exp=1", i, bus.rsp_valid); end
      if (bus.rsp_rdata !== e.rdata) begin errors++; $display("[TB] FAIL bp_rdata cyc=%0d got=%h exp=%h", i, bus.rsp_rdata, e.rdata); end
      if (bus.req_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_ready cyc=%0d got=%b exp=0", i, bus.req_ready); end
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks += 2;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_after_valid got=%b exp=0", bus.rsp_valid); end
    if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_after_ready got=%b exp=1", bus.req_ready); end
  endtask

  task automatic test_reset_abort();
    int w, lat;
    exp_t e;
    bus.rsp_ready = 1'b1;
    issue_req(1'b1, 1'b0, 16'h0060, 32'hA5A5A5A5, 1'b1, w);
    collect(lat, e);
    issue_req(1'b0, 1'b0, 16'h0060, 32'h0, 1'b1, w);
    collect(lat, e);
    @(negedge clk);
    // Abort in WAIT, then again with the reset edge landing on the ACCESS edge.
    for (int k = 0; k < 2; k++) begin
      issue_req(1'b1, 1'b0, 16'h0060, 32'h5A5A5A5A, 1'b0, w);
      if (k == 1) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_busy k=%0d got=%b exp=1", k, busy); end
      rst_f = 1'b1;
      @(negedge clk);
      rst_f = 1'b0;
      checks += 4;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle k=%0d got=%b exp=0", k, busy); end
      if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_ready k=%0d got=%b exp=1", k, bus.req_ready); end
      if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_valid k=%0d got=%b exp=0", k, bus.rsp_valid); end
      if (bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL abort_rsp k=%0d got=%h/%b exp=0/0", k, bus.rsp_rdata, bus.rsp_err);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_rsp k=%0d got=%b exp=0", k, bus.rsp_valid); end
      issue_req(1'b0, 1'b0, 16'h0060, 32'h0, 1'b1, w);
      collect(lat, e);
      checks++;
      if (bus.rsp_rdata !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL abort_mem k=%0d got=%h exp=a5a5a5a5", k, bus.rsp_rdata); end
      @(negedge clk);
    end
  endtask

  task automatic test_protection();
    int w, lat;
    exp_t e;
    logic [15:0] addrs [2];
    addrs = '{16'h0020, 16'h0040};
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      issue_req(1'b1, 1'b0, addrs[i], 32'h77000000 | 32'(addrs[i]), 1'b1, w);
      collect(lat, e);
      checks++;
      if (bus.rsp_err !== e.err) begin errors++; $display("[TB] FAIL prot_wr_err addr=%h got=%b exp=%b", addrs[i], bus.rsp_err, e.err); end
    end
    for (int i = 0; i < 2; i++) begin
      issue_req(1'b0, 1'b0, addrs[i], 32'h0, 1'b1, w);
      collect(lat, e);
      checks++;
      if (bus.rsp_rdata !== e.rdata) begin errors++; $display("[TB] FAIL prot_rd addr=%h got=%h exp=%h", addrs[i], bus.rsp_rdata, e.rdata); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int w, lat;
    exp_t e;
    logic [15:0] a;
    logic [31:0] d;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = 16'h0080 + 16'($urandom_range(0, 127));
      d = $urandom;
      issue_req(1'b1, 1'b0, a, d, 1'b1, w);
      collect(lat, e);
      checks++;
      if (bus.rsp_err !== e.err) begin errors++; $display("[TB] FAIL b2b_wr_err addr=%h got=%b exp=%b", a, bus.rsp_err, e.err); end
      issue_req(1'b0, 1'b0, a, 32'h0, 1'b1, w);
      checks++;
      if (w !== 0) begin errors++; $display("[TB] FAIL b2b_issue_gap got=%0d exp=0", w); end
      collect(lat, e);
      checks += 2;
      if (lat !== WAIT_CYCLES + 1) begin errors++; $display("[TB] FAIL b2b_latency got=%0d exp=%0d", lat, WAIT_CYCLES + 1); end
      if (bus.rsp_rdata !== d) begin errors++; $display("[TB] FAIL b2b_rdata addr=%h got=%h exp=%h", a, bus.rsp_rdata, d); end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_ifetch_we();
    test_backpressure();
    test_reset_abort();
    test_protection();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
